// File: rtl/hv_pwm_stat_encode.sv
// Serialises a status vector onto the gate-wave PWM return channel as preamble + data (MSB first) + optional even parity.
// Optional feature macro: HV_PWM_STAT_PARITY_EN (adds the trailing parity symbol).
module hv_pwm_stat_encode #(
    parameter int NUM_FLAG  = 4,
    parameter int SYM_CYC   = 8,
    parameter int GAP_CYC   = 4,
    parameter int WDG_CNT_W = 16,
    parameter int WDG_TH0   = 1000,
    parameter int WDG_TH1   = 2000,
    parameter int WDG_TH2   = 4000,
    parameter int WDG_TH3   = 8000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_hv_pwm_gwave,
    input  logic [NUM_FLAG-1:0] i_flag,
    input  logic                i_wdg_en,
    input  logic [1:0]          i_wdg_sel,
    output logic                o_hv_pwm_stat,
    output logic                o_busy,
    output logic [NUM_FLAG-1:0] o_sent_flag,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam int CNT_MAX = (SYM_CYC > GAP_CYC) ? SYM_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int BIT_W   = (NUM_FLAG > 1) ? $clog2(NUM_FLAG) : 1;

    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(NUM_FLAG - 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     sym_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [WDG_CNT_W-1:0] wdg_cnt, wdg_last;
    logic                 gw_lock;
    logic                 chg, wdg_hit, start, sym_end, gap_end;
    logic                 sym_bit, stat_nxt;

    always_comb begin
        case (i_wdg_sel)
            2'd0:    wdg_last = WDG_CNT_W'(WDG_TH0 - 1);
            2'd1:    wdg_last = WDG_CNT_W'(WDG_TH1 - 1);
            2'd2:    wdg_last = WDG_CNT_W'(WDG_TH2 - 1);
            default: wdg_last = WDG_CNT_W'(WDG_TH3 - 1);
        endcase
    end

    // Comparing against the sent snapshot means changes seen mid-frame re-trigger once back in IDLE.
    assign chg     = (i_flag != o_sent_flag);
    assign wdg_hit = i_wdg_en && (wdg_cnt == wdg_last);
    assign start   = chg || wdg_hit;
    assign sym_end = (sym_cnt == SYM_LAST);
    assign gap_end = (sym_cnt == GAP_LAST);

    always_comb begin
        state_nxt = state;
        sym_bit   = 1'b1;
        stat_nxt  = i_hv_pwm_gwave;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_PRE;
            end
            ST_PRE: begin
                stat_nxt = gw_lock ^ sym_bit;
                if (sym_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                sym_bit  = o_sent_flag[bit_idx];
                stat_nxt = gw_lock ^ sym_bit;
                if (sym_end && (bit_idx == '0)) begin
`ifdef HV_PWM_STAT_PARITY_EN
                    state_nxt = ST_PAR;
`else
                    state_nxt = ST_GAP;
`endif
                end
            end
`ifdef HV_PWM_STAT_PARITY_EN
            ST_PAR: begin
                sym_bit  = ^o_sent_flag;
                stat_nxt = gw_lock ^ sym_bit;
                if (sym_end) state_nxt = ST_GAP;
            end
`endif
            ST_GAP: begin
                if (gap_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            o_hv_pwm_stat <= 1'b0;
            o_busy        <= 1'b0;
            o_sent_flag   <= '0;
            gw_lock       <= 1'b0;
            sym_cnt       <= '0;
            bit_idx       <= '0;
            wdg_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            o_hv_pwm_stat <= stat_nxt;
            // Registered so busy lines up with the first symbol level on the output.
            o_busy        <= (state != ST_IDLE);

            if ((state == ST_IDLE) && start) begin
                o_sent_flag <= i_flag;
                gw_lock     <= i_hv_pwm_gwave;
            end

            if ((state == ST_IDLE) || (state_nxt != state) || ((state != ST_GAP) && sym_end))
                sym_cnt <= '0;
            else
                sym_cnt <= sym_cnt + 1'b1;

            if ((state == ST_IDLE) && start)
                bit_idx <= '0;
            else if ((state == ST_PRE) && sym_end)
                bit_idx <= BIT_TOP;
            else if ((state == ST_DATA) && sym_end && (bit_idx != '0))
                bit_idx <= bit_idx - 1'b1;

            // Watchdog only runs between frames; a hit wraps it even if it lands in GAP.
            if (!i_wdg_en || !((state == ST_IDLE) || (state == ST_GAP)))
                wdg_cnt <= '0;
            else if (((state == ST_IDLE) && start) || wdg_hit)
                wdg_cnt <= '0;
            else
                wdg_cnt <= wdg_cnt + 1'b1;
        end
    end

    assign o_dbg_state = state;

endmodule
